// File: rtl/imem_prefetch.sv
// Instruction prefetch buffer: issues word fetches under a credit limit and queues in-order
// responses in a small FIFO. A redirect flushes the FIFO and drops responses still in flight.
module imem_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t DepthCnt = cnt_t'(DEPTH);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        discard_q, discard_d;
    cnt_t        count_q, count_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic [31:0] data_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    logic [31:0] redirect_addr;
    logic [CntW:0] credit_used;
    logic        grant;
    logic        rsp_fire;
    logic        rsp_drop;
    logic        rsp_keep;
    logic        push_en;
    logic        pop_en;
    logic        unused_redirect_lsb;

    assign redirect_addr       = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Buffered plus in-flight words may never exceed the FIFO, so a response always fits.
    assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};

    // Gating with reset keeps the request low while the asynchronous clear is held.
    assign mem_req     = reset && !redirect && (credit_used < {1'b0, DepthCnt});
    assign mem_addr    = fetch_pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];

    always_comb begin
        grant    = mem_req && mem_gnt;
        rsp_fire = mem_rvalid && (outstanding_q != '0);
        rsp_drop = rsp_fire && (discard_q != '0);
        rsp_keep = rsp_fire && (discard_q == '0);
        push_en  = rsp_keep && !redirect;
        pop_en   = instr_valid && instr_ready && !redirect;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q + cnt_t'(grant) - cnt_t'(rsp_fire);

        if (redirect) begin
            // Every word still in flight belongs to the old stream and must be dropped.
            fetch_pc_d = redirect_addr;
            resp_pc_d  = redirect_addr;
            discard_d  = outstanding_q - cnt_t'(rsp_fire);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_keep) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (rsp_drop) begin
                discard_d = discard_q - cnt_t'(1);
            end
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push_en) - cnt_t'(pop_en);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push_en) begin
            data_q[wr_ptr_q] <= mem_rdata;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

`ifndef SYNTHESIS
    addr_stable_a: assert property (@(posedge clk) disable iff (!reset)
        mem_req && !mem_gnt |=> mem_addr == $past(mem_addr));

    no_overflow_a: assert property (@(posedge clk) disable iff (!reset)
        push_en && !pop_en |-> count_q != DepthCnt);
`endif

endmodule

// File: tb/tb_imem_prefetch.sv
// Scoreboard bench for imem_prefetch: a latency-configurable memory model answers grants,
// directed tests queue the expected instruction stream, and a monitor checks every pop.
module tb_imem_prefetch;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] XorKey = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    always #5 clk = ~clk;

    imem_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    exp_t        sb[$];
    pend_t       pend[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pops = 0;
    int unsigned grant_count = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = pc ^ XorKey;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_instr_pc"}, instr_pc, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk_reset_outputs("rst");
        tick(1);
        reset = 1'b1;
        #1;
        chk("rel_mem_req", 32'(mem_req), 32'd1);
        chk("rel_mem_addr", mem_addr, 32'h0000_0000);
    endtask

    // Memory model: responses returned in order, each lat cycles after its grant edge.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (mem_req && mem_gnt) begin
                pend.push_back('{addr: mem_addr, due: cyc + lat});
                grant_count++;
            end
            #1;
            if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend[0].addr ^ XorKey;
                void'(pend.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
        end
    end

    // Monitor: every accepted instruction must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && !redirect && instr_valid && instr_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual_pc=%h required=none", instr_pc);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", instr_pc, e.pc);
                    chk("sb_instr", instr, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int unsigned g0;
        int unsigned p0;

        // Streaming after reset: one instruction per cycle.
        mem_gnt     = 1'b1;
        instr_ready = 1'b1;
        lat         = 1;
        tick(2);
        chk_reset_outputs("init");
        reset = 1'b1;
        #1;
        chk("init_rel_req", 32'(mem_req), 32'd1);
        chk("init_rel_addr", mem_addr, 32'h0000_0000);
        g0 = grant_count;
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        expect_pc(32'hC);
        tick(2);
        p0 = pops;
        tick(2);
        mem_gnt = 1'b0;
        tick(2);
        chk("stream_pops", pops - p0, 32'd4);
        chk("stream_grants", grant_count - g0, 32'd4);
        tick(3);
        chk("stream_sb_empty", sb.size(), 32'd0);

        // Stalled consumer: credit stops after DEPTH grants.
        instr_ready = 1'b0;
        mem_gnt     = 1'b1;
        do_reset();
        g0 = grant_count;
        tick(8);
        chk("stall_grants", grant_count - g0, 32'd4);
        chk("stall_mem_req", 32'(mem_req), 32'd0);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        chk("stall_pc", instr_pc, 32'h0);
        chk("stall_instr", instr, 32'hA5A5_A5A5);
        mem_gnt = 1'b0;
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        expect_pc(32'hC);
        instr_ready = 1'b1;
        tick(6);
        chk("resume_req", 32'(mem_req), 32'd1);
        chk("resume_addr", mem_addr, 32'h10);
        chk("resume_sb_empty", sb.size(), 32'd0);
        tick(5);
        chk("hold_addr16", mem_addr, 32'h10);

        // Redirect with two slow responses in flight.
        lat     = 3;
        mem_gnt = 1'b1;
        do_reset();
        tick(2);
        mem_gnt     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        chk("redir_req_low", 32'(mem_req), 32'd0);
        expect_pc(32'h100);
        expect_pc(32'h104);
        tick(1);
        redirect = 1'b0;
        mem_gnt  = 1'b1;
        #1;
        chk("post_redir_req", 32'(mem_req), 32'd1);
        chk("post_redir_addr", mem_addr, 32'h100);
        chk("post_redir_valid", 32'(instr_valid), 32'd0);
        tick(2);
        mem_gnt = 1'b0;
        tick(6);
        chk("redir_sb_empty", sb.size(), 32'd0);

        // Back-to-back redirects; one stale response lands during the second.
        mem_gnt = 1'b1;
        tick(2);
        mem_gnt     = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick(1);
        redirect_pc = 32'h300;
        #1;
        chk("b2b_req_low", 32'(mem_req), 32'd0);
        expect_pc(32'h300);
        expect_pc(32'h304);
        tick(1);
        redirect = 1'b0;
        mem_gnt  = 1'b1;
        #1;
        chk("b2b_addr", mem_addr, 32'h300);
        tick(2);
        mem_gnt = 1'b0;
        tick(7);
        chk("b2b_sb_empty", sb.size(), 32'd0);
        chk("b2b_valid", 32'(instr_valid), 32'd0);

        // Address wrap at the top of the address space.
        lat         = 1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        expect_pc(32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        tick(1);
        redirect = 1'b0;
        mem_gnt  = 1'b1;
        tick(3);
        mem_gnt = 1'b0;
        tick(5);
        chk("wrap_sb_empty", sb.size(), 32'd0);

        // Grant withheld, then an asynchronous reset pulse mid-stream.
        lat         = 2;
        mem_gnt     = 1'b0;
        instr_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("nognt_req", 32'(mem_req), 32'd1);
            chk("nognt_addr", mem_addr, 32'h0);
        end
        instr_ready = 1'b0;
        mem_gnt     = 1'b1;
        tick(4);
        mem_gnt = 1'b0;
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        chk("pre_rst_pc", instr_pc, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async");
        tick(1);
        reset = 1'b1;
        tick(4);
        chk("stale_ignored", 32'(instr_valid), 32'd0);
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", mem_addr, 32'h0);
        expect_pc(32'h0);
        expect_pc(32'h4);
        instr_ready = 1'b1;
        mem_gnt     = 1'b1;
        tick(2);
        mem_gnt = 1'b0;
        tick(6);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
